// File: rtl/controller_poller.sv
// controller_poller: polls two serial game controllers in parallel.
// A start request pulses the shared latch, then clocks eight bits out of
// each controller. Bits arrive active-low, get inverted, and are shifted in
// MSB-first. When all eight are in, both bytes are published together with
// a one-cycle valid pulse.
module controller_poller #(
  parameter int HalfPeriodCycles = 2,
  parameter int NumButtons       = 8
) (
  input  logic                  clk_1,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  valid,
  output logic                  controller_latch,
  output logic                  controller_clk_out,
  input  logic                  controller_1_data_in_B,
  input  logic                  controller_2_data_in_B,
  output logic [NumButtons-1:0] controller_1_buttons_out,
  output logic [NumButtons-1:0] controller_2_buttons_out
);

  localparam int CNT_W = $clog2(2 * HalfPeriodCycles + 1);
  localparam int BIT_W = $clog2(NumButtons);

  // Counters hold "cycles remaining minus one" so a phase ends when they reach 0.
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HalfPeriodCycles - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HalfPeriodCycles - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(NumButtons - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_W-1:0]      r_bit;
  logic [NumButtons-1:0] r_sr1;
  logic [NumButtons-1:0] r_sr2;
  logic [NumButtons-1:0] r_btn1;
  logic [NumButtons-1:0] r_btn2;
  logic                  r_busy;
  logic                  r_valid;
  logic                  r_latch;
  logic                  r_clk;

  // Poll sequencer: every output is a register updated on the transition
  // into the state that owns it, so the pins never see a combinational path.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sr1   <= '0;
      r_sr2   <= '0;
      r_btn1  <= '0;
      r_btn2  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_latch <= 1'b0;
      r_clk   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LATCH;
            r_cnt   <= LATCH_LAST;
            r_busy  <= 1'b1;
            r_latch <= 1'b1;
          end
        end
        LATCH: begin
          if (r_cnt == '0) begin
            r_state <= LOW;
            r_cnt   <= HALF_LAST;
            r_bit   <= '0;
            r_latch <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        LOW: begin
          // Sample at the end of the low half, just before the rising edge
          // that tells the controllers to move on to their next bit.
          if (r_cnt == '0) begin
            r_sr1   <= {r_sr1[NumButtons-2:0], ~controller_1_data_in_B};
            r_sr2   <= {r_sr2[NumButtons-2:0], ~controller_2_data_in_B};
            r_state <= HIGH;
            r_cnt   <= HALF_LAST;
            r_clk   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HIGH: begin
          if (r_cnt == '0) begin
            r_clk <= 1'b0;
            if (r_bit == LAST_BIT) begin
              // Publish both bytes at once; they are visible during DONE.
              r_state <= DONE;
              r_cnt   <= '0;
              r_btn1  <= r_sr1;
              r_btn2  <= r_sr2;
              r_valid <= 1'b1;
            end else begin
              r_state <= LOW;
              r_cnt   <= HALF_LAST;
              r_bit   <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_latch <= 1'b0;
          r_clk   <= 1'b0;
        end
      endcase
    end
  end

  assign busy                     = r_busy;
  assign valid                    = r_valid;
  assign controller_latch         = r_latch;
  assign controller_clk_out       = r_clk;
  assign controller_1_buttons_out = r_btn1;
  assign controller_2_buttons_out = r_btn2;

endmodule
